// File: rtl/fir_mac_sequencer.sv
// ============================================================================
// Module      : fir_mac_sequencer
// Description : Time-multiplexed FIR filter sequencer that drives an external
//               multiplier and a registered external adder, one tap per cycle.
//               Optional macro FIR_SAMPLE_CNT_EN adds a completed-output counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_mac_sequencer #(
    parameter int NUM_TAPS = 8,
    parameter int MULT_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [15:0]                 in_data,
    input  logic                        coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
    input  logic [15:0]                 coef_wdata,
    output logic [15:0]                 mult_a,
    output logic [15:0]                 mult_b,
    input  logic [31:0]                 mult_result,
    output logic [31:0]                 add_acc_in,
    output logic [31:0]                 add_mult_out,
    input  logic [31:0]                 add_acc_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_data,
    output logic                        busy
`ifdef FIR_SAMPLE_CNT_EN
    ,
    output logic [15:0]                 sample_cnt
`endif
);

    localparam int                c_aw       = $clog2(NUM_TAPS);
    localparam logic [c_aw-1:0]   c_last_tap = c_aw'(NUM_TAPS - 1);
    localparam logic [c_aw:0]     c_num_taps = (c_aw + 1)'(NUM_TAPS);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_mac   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_out   = 2'd3;

    logic [1:0]          r_state;
    logic [c_aw-1:0]     r_tap;
    logic [15:0]         r_x    [NUM_TAPS];
    logic [15:0]         r_coef [NUM_TAPS];
    logic [MULT_LAT-1:0] r_trk_vld;
    logic [MULT_LAT-1:0] r_trk_first;
    logic [MULT_LAT-1:0] r_trk_last;
    logic                r_sum_rdy;
    logic                r_out_valid;
    logic [31:0]         r_out_data;
`ifdef FIR_SAMPLE_CNT_EN
    logic [15:0]         r_sample_cnt;
`endif

    logic w_issue;
    logic w_cons;
    logic w_cons_first;
    logic w_addr_ok;

    assign w_issue      = (r_state == c_st_mac);
    assign w_cons       = r_trk_vld[MULT_LAT-1];
    assign w_cons_first = r_trk_first[MULT_LAT-1];
    assign w_addr_ok    = ({1'b0, coef_addr} < c_num_taps);

    assign in_ready     = (r_state == c_st_idle);
    assign busy         = (r_state != c_st_idle);
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
`ifdef FIR_SAMPLE_CNT_EN
    assign sample_cnt   = r_sample_cnt;
`endif

    assign mult_a       = w_issue ? r_x[r_tap]    : 16'd0;
    assign mult_b       = w_issue ? r_coef[r_tap] : 16'd0;
    assign add_mult_out = w_cons ? mult_result : 32'd0;
    // Tap 0 starts a fresh accumulation instead of adding to the stale sum.
    assign add_acc_in   = (w_cons && !w_cons_first) ? add_acc_out : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_tap       <= '0;
            r_trk_vld   <= '0;
            r_trk_first <= '0;
            r_trk_last  <= '0;
            r_sum_rdy   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_x[i]    <= 16'd0;
                r_coef[i] <= 16'd0;
            end
`ifdef FIR_SAMPLE_CNT_EN
            r_sample_cnt <= 16'd0;
`endif
        end else begin
            r_trk_vld[0]   <= w_issue;
            r_trk_first[0] <= w_issue && (r_tap == '0);
            r_trk_last[0]  <= w_issue && (r_tap == c_last_tap);
            for (int k = 1; k < MULT_LAT; k++) begin
                r_trk_vld[k]   <= r_trk_vld[k-1];
                r_trk_first[k] <= r_trk_first[k-1];
                r_trk_last[k]  <= r_trk_last[k-1];
            end
            // The adder captures the final sum on the same edge this is set.
            r_sum_rdy <= w_cons && r_trk_last[MULT_LAT-1];

            case (r_state)
                c_st_idle: begin
                    if (coef_we && w_addr_ok) begin
                        r_coef[coef_addr] <= coef_wdata;
                    end
                    if (in_valid) begin
                        r_x[0] <= in_data;
                        for (int i = 1; i < NUM_TAPS; i++) begin
                            r_x[i] <= r_x[i-1];
                        end
                        r_tap   <= '0;
                        r_state <= c_st_mac;
                    end
                end
                c_st_mac: begin
                    if (r_tap == c_last_tap) begin
                        r_tap   <= '0;
                        r_state <= c_st_drain;
                    end else begin
                        r_tap <= r_tap + c_aw'(1);
                    end
                end
                c_st_drain: begin
                    if (r_sum_rdy) begin
                        r_out_data  <= add_acc_out;
                        r_out_valid <= 1'b1;
                        r_state     <= c_st_out;
                    end
                end
                c_st_out: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_st_idle;
`ifdef FIR_SAMPLE_CNT_EN
                        r_sample_cnt <= r_sample_cnt + 16'd1;
`endif
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// ============================================================================
// Module      : tb_fir_mac_sequencer
// Description : Self-checking bench for fir_mac_sequencer with a behavioural
//               multiplier/adder and a sum-of-products reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_mac_sequencer;

    localparam int c_n   = 8;
    localparam int c_l   = 1;
    localparam int c_lat = c_n + c_l + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'd0;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = 3'd0;
    logic [15:0] coef_wdata = 16'd0;
    logic [15:0] mult_a;
    logic [15:0] mult_b;
    logic [31:0] mult_result;
    logic [31:0] add_acc_in;
    logic [31:0] add_mult_out;
    logic [31:0] add_acc_out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        busy;
`ifdef FIR_SAMPLE_CNT_EN
    logic [15:0] sample_cnt;
`endif

    fir_mac_sequencer #(
        .NUM_TAPS (c_n),
        .MULT_LAT (c_l)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_wdata   (coef_wdata),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_result  (mult_result),
        .add_acc_in   (add_acc_in),
        .add_mult_out (add_mult_out),
        .add_acc_out  (add_acc_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
`ifdef FIR_SAMPLE_CNT_EN
        ,
        .sample_cnt   (sample_cnt)
`endif
    );

    always #5 clk = ~clk;

    // External signed multiplier with c_l registered stages.
    logic [31:0] r_mpipe [c_l];
    always @(posedge clk) begin
        r_mpipe[0] <= $signed(mult_a) * $signed(mult_b);
        for (int k = 1; k < c_l; k++) r_mpipe[k] <= r_mpipe[k-1];
    end
    assign mult_result = r_mpipe[c_l-1];

    // External adder with one registered stage.
    always @(posedge clk) begin
        if (rst) add_acc_out <= 32'd0;
        else     add_acc_out <= add_acc_in + add_mult_out;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference model: delay window, coefficients and a pending result due at a cycle.
    logic signed [15:0] mx [c_n];
    logic signed [15:0] mc [c_n];
    logic signed [31:0] m_res;
    logic [31:0]        m_outd = 32'd0;
    bit                 m_busy = 1'b0;
    bit                 m_outv = 1'b0;
    int                 m_due = 0;
    int                 m_cnt = 0;
    int                 n_cyc = 0;
    int                 acc_cyc = 0;
    bit                 prev_ov = 1'b0;
    logic [31:0]        q_got [$];

    always @(negedge clk) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_outv});
        chk("out_data", out_data, m_outd);
`ifdef FIR_SAMPLE_CNT_EN
        chk("sample_cnt", {16'd0, sample_cnt}, m_cnt[31:0] & 32'hFFFF);
`endif
        if (out_valid && !prev_ov) chk("latency", n_cyc - acc_cyc, c_lat);
        prev_ov = out_valid;
        if (out_valid && out_ready) q_got.push_back(out_data);

        if (rst) begin
            m_busy = 1'b0;
            m_outv = 1'b0;
            m_outd = 32'd0;
            m_cnt  = 0;
            for (int k = 0; k < c_n; k++) begin
                mx[k] = 16'sd0;
                mc[k] = 16'sd0;
            end
        end else if (!m_busy) begin
            if (coef_we) mc[coef_addr] = coef_wdata;
            if (in_valid) begin
                for (int k = c_n - 1; k > 0; k--) mx[k] = mx[k-1];
                mx[0] = in_data;
                m_res = 32'sd0;
                for (int k = 0; k < c_n; k++) m_res = m_res + mc[k] * mx[k];
                m_busy  = 1'b1;
                m_due   = n_cyc + c_lat;
                acc_cyc = n_cyc;
            end
        end else if (m_outv) begin
            if (out_ready) begin
                m_outv = 1'b0;
                m_busy = 1'b0;
                m_cnt++;
            end
        end else if (n_cyc + 1 == m_due) begin
            m_outv = 1'b1;
            m_outd = m_res;
        end
        n_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic send(input logic [15:0] s);
        in_valid = 1'b1; in_data = s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (c_lat + 1) tick();
    endtask

    logic [31:0] exp_res [17] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd0,
                                   32'd100, 32'd50, 32'd75, 32'd85, 32'd85, 32'd0, 32'd4, 32'd10};

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // Impulse response with coef[k] = k+1; last coef written alongside the accept.
        for (int k = 0; k < 7; k++) wr(k[2:0], 16'(k + 1));
        coef_we = 1'b1; coef_addr = 3'd7; coef_wdata = 16'd8;
        in_valid = 1'b1; in_data = 16'd1;
        tick();
        coef_we = 1'b0; in_valid = 1'b0;
        settle();
        for (int j = 0; j < 8; j++) begin
            send(16'd0);
            settle();
        end

        // Unity coefficients with mixed-sign samples.
        for (int k = 0; k < 8; k++) wr(k[2:0], 16'd1);
        send(16'd100);    settle();
        send(-16'sd50);   settle();
        send(16'd25);     settle();

        // Back-pressure in OUT with a competing sample offered.
        out_ready = 1'b0;
        send(16'd10);
        repeat (10) tick();
        in_valid = 1'b1; in_data = 16'd999;
        repeat (5) tick();
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_out_data", out_data, 32'd85);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        send(16'd0);
        settle();

        // Reset in the fourth MAC cycle.
        send(16'd7);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        settle();
        send(16'd1);
        settle();

        // Coefficient write during MAC must be dropped.
        for (int k = 0; k < 8; k++) wr(k[2:0], 16'(k + 1));
        send(16'd2);
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'h7FFF;
        tick();
        coef_we = 1'b0;
        settle();
        send(16'd3);
        settle();

        chk("n_results", q_got.size(), 32'd17);
        for (int i = 0; i < 17; i++)
            chk("result", (i < q_got.size()) ? q_got[i] : 32'hDEADBEEF, exp_res[i]);
`ifdef FIR_SAMPLE_CNT_EN
        chk("sample_cnt_final", {16'd0, sample_cnt}, 32'd3);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
